// File: rtl/calc_pkg.sv
// calc_pkg: shared key codes, operator encodings, FSM states and helpers for the calculator entry stage.
//   Key codes 0-9 are digits; A-F are the command keys named below.
//   Operator encodings match the ALU op_sel bus.
package calc_pkg;

    localparam int          DEF_NDIG     = 4;
    localparam logic [15:0] DEF_ERR_WORD = 16'hFFFF;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_MOD = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_MOD = 2'd3;

    typedef enum logic [2:0] {S_A, S_OP, S_B, S_EXEC, S_RES, S_ERR} state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k < 4'd10;
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return k >= KEY_ADD && k <= KEY_MOD;
    endfunction

    function automatic logic [1:0] key_to_op(input logic [3:0] k);
        logic [3:0] d;
        d = k - KEY_ADD;
        return d[1:0];
    endfunction

    // Number of significant digits, so a loaded value keeps a consistent digit count.
    function automatic logic [2:0] sig_digits(input logic [15:0] v);
        return v[15:12] != 4'd0 ? 3'd4 :
               v[11:8]  != 4'd0 ? 3'd3 :
               v[7:4]   != 4'd0 ? 3'd2 :
               v[3:0]   != 4'd0 ? 3'd1 : 3'd0;
    endfunction

endpackage

// File: rtl/bcd_digit_reg.sv
// bcd_digit_reg: packed BCD operand register with digit count and leading-zero suppression.
//   clk, rst       clock and synchronous active-high reset
//   clr            empty the operand (may coincide with shift_en to restart with one digit)
//   load_en        replace the operand with load_val
//   load_val[15:0] BCD value to load
//   shift_en       shift digit in as the new least-significant digit
//   digit[3:0]     BCD digit to shift in
//   value[15:0]    current operand
//   full           NDIG digits held; further digits are dropped
module bcd_digit_reg
    import calc_pkg::*;
#(
    parameter int NDIG = DEF_NDIG
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load_en,
    input  logic [15:0] load_val,
    input  logic        shift_en,
    input  logic [3:0]  digit,
    output logic [15:0] value,
    output logic        full
);

    logic [2:0]  cnt;
    logic [15:0] base_v;
    logic [2:0]  base_c;

    // A clear in the same cycle as a shift starts a fresh operand with this digit.
    assign base_v = clr ? 16'h0 : value;
    assign base_c = clr ? 3'd0 : cnt;
    assign full   = cnt == 3'(NDIG);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= 16'h0;
            cnt   <= 3'd0;
        end else if (load_en) begin
            value <= load_val;
            cnt   <= sig_digits(load_val);
        end else if (shift_en && base_c != 3'(NDIG)) begin
            // Zero onto an empty operand is not counted as a digit.
            value <= {base_v[11:0], digit};
            cnt   <= (base_v == 16'h0 && digit == 4'd0) ? 3'd0 : base_c + 3'd1;
        end else begin
            value <= base_v;
            cnt   <= base_c;
        end
    end

endmodule

// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: keypad entry FSM feeding the BCD ALU and driving the display word and flags.
//   key_valid/key_code/key_ready   keypad handshake; keys dropped while key_ready is low
//   op_a, op_b, op_sel             operand and operator buses to the ALU
//   sum, diff, prod, rem + flags   combinational ALU results
//   display, disp_neg, error       display word, sign and error indication
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int          NDIG     = DEF_NDIG,
    parameter logic [15:0] ERR_WORD = DEF_ERR_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic [1:0]  op_sel,
    input  logic [15:0] sum,
    input  logic [15:0] diff,
    input  logic [15:0] prod,
    input  logic [15:0] rem,
    input  logic        sum_cout,
    input  logic        diff_neg,
    input  logic        prod_ovf,
    input  logic        div0,
    output logic [15:0] display,
    output logic        disp_neg,
    output logic        error
);

    state_t      state, state_n;
    logic [15:0] res;
    logic        res_neg;
    logic        acc, dig, opk, eqk, clrk;
    logic        a_clr, a_shift, a_load, b_clr, b_shift, sel_ld, res_ld, clr_all;
    logic        a_full, b_full;
    logic        err_flag;
    logic [15:0] res_sel;

    assign key_ready = state != S_EXEC;
    assign acc       = key_valid & key_ready;
    assign dig       = acc & is_digit(key_code);
    assign opk       = acc & is_op(key_code);
    assign eqk       = acc & (key_code == KEY_EQ);
    assign clrk      = acc & (key_code == KEY_CLR);

    assign res_sel  = op_sel == OP_ADD ? sum  : op_sel == OP_SUB ? diff : op_sel == OP_MUL ? prod : rem;
    assign err_flag = op_sel == OP_ADD ? sum_cout : op_sel == OP_SUB ? 1'b0 : op_sel == OP_MUL ? prod_ovf : div0;

    always_comb begin
        state_n = state;
        a_clr   = 1'b0;
        a_shift = 1'b0;
        a_load  = 1'b0;
        b_clr   = 1'b0;
        b_shift = 1'b0;
        sel_ld  = 1'b0;
        res_ld  = 1'b0;
        clr_all = 1'b0;
        case (state)
            S_A: begin
                a_shift = dig & ~a_full;
                sel_ld  = opk;
                state_n = opk ? S_OP : S_A;
            end
            S_OP: begin
                sel_ld  = opk;
                b_clr   = dig;
                b_shift = dig;
                state_n = dig ? S_B : S_OP;
            end
            S_B: begin
                b_shift = dig & ~b_full;
                state_n = eqk ? S_EXEC : S_B;
            end
            S_EXEC: begin
                res_ld  = 1'b1;
                state_n = err_flag ? S_ERR : S_RES;
            end
            S_RES: begin
                if (dig) begin
                    a_clr   = 1'b1;
                    b_clr   = 1'b1;
                    a_shift = 1'b1;
                    state_n = S_A;
                end else if (opk && !res_neg) begin
                    // Chaining: the shown result becomes the next left operand.
                    a_load  = 1'b1;
                    sel_ld  = 1'b1;
                    b_clr   = 1'b1;
                    state_n = S_OP;
                end
            end
            S_ERR: state_n = S_ERR;
            default: state_n = S_A;
        endcase
        if (clrk) begin
            clr_all = 1'b1;
            a_clr   = 1'b1;
            b_clr   = 1'b1;
            a_shift = 1'b0;
            b_shift = 1'b0;
            a_load  = 1'b0;
            sel_ld  = 1'b0;
            state_n = S_A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_A;
            op_sel  <= OP_ADD;
            res     <= 16'h0;
            res_neg <= 1'b0;
        end else begin
            state <= state_n;
            if (clr_all)
                op_sel <= OP_ADD;
            else if (sel_ld)
                op_sel <= key_to_op(key_code);
            if (clr_all) begin
                res     <= 16'h0;
                res_neg <= 1'b0;
            end else if (res_ld) begin
                res     <= res_sel;
                res_neg <= (op_sel == OP_SUB) & diff_neg;
            end
        end
    end

    bcd_digit_reg #(.NDIG(NDIG)) u_a (
        .clk      (clk),
        .rst      (rst),
        .clr      (a_clr),
        .load_en  (a_load),
        .load_val (res),
        .shift_en (a_shift),
        .digit    (key_code),
        .value    (op_a),
        .full     (a_full)
    );

    bcd_digit_reg #(.NDIG(NDIG)) u_b (
        .clk      (clk),
        .rst      (rst),
        .clr      (b_clr),
        .load_en  (1'b0),
        .load_val (16'h0),
        .shift_en (b_shift),
        .digit    (key_code),
        .value    (op_b),
        .full     (b_full)
    );

    // Display tracks the operand being edited; op_b stays visible while the ALU settles.
    assign display  = state == S_RES ? res :
                      state == S_ERR ? ERR_WORD :
                      (state == S_B || state == S_EXEC) ? op_b : op_a;
    assign disp_neg = (state == S_RES) & res_neg;
    assign error    = state == S_ERR;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb_calc_entry_ctrl: directed keypad sequences with a queued expected-response scoreboard.
module tb_calc_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        key_ready, disp_neg, error;
    logic [15:0] op_a, op_b, display, sum, diff, prod, rem;
    logic [1:0]  op_sel;
    logic        sum_cout, diff_neg, prod_ovf, div0;
    int          ia, ib;

    always #5 clk = ~clk;

    calc_entry_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .sum       (sum),
        .diff      (diff),
        .prod      (prod),
        .rem       (rem),
        .sum_cout  (sum_cout),
        .diff_neg  (diff_neg),
        .prod_ovf  (prod_ovf),
        .div0      (div0),
        .display   (display),
        .disp_neg  (disp_neg),
        .error     (error)
    );

    function automatic int b2i(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] i2b(input int x);
        return {4'(x / 1000 % 10), 4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
    endfunction

    // Behavioural 4-digit BCD ALU
    assign ia       = b2i(op_a);
    assign ib       = b2i(op_b);
    assign sum      = i2b((ia + ib) % 10000);
    assign sum_cout = (ia + ib) > 9999;
    assign diff     = i2b(ia >= ib ? ia - ib : ib - ia);
    assign diff_neg = ia < ib;
    assign prod     = i2b((ia * ib) % 10000);
    assign prod_ovf = (ia * ib) > 9999;
    assign rem      = (ib == 0) ? 16'h0 : i2b(ia % (ib == 0 ? 1 : ib));
    assign div0     = ib == 0;

    typedef struct {
        string       name;
        bit          full;
        logic [15:0] disp;
        logic        neg;
        logic        err;
        logic        rdy;
        logic [15:0] opa;
        logic [15:0] opb;
        logic [1:0]  sel;
    } exp_t;

    exp_t probe_q[$];
    exp_t res_q[$];
    int   checks = 0;
    int   fails = 0;
    logic rdy_q = 1'b1;

    function automatic exp_t ex(input string n, input logic [15:0] d, input logic ng, input logic er,
                                input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
        exp_t e;
        e.name = n;
        e.full = 1'b1;
        e.disp = d;
        e.neg  = ng;
        e.err  = er;
        e.rdy  = 1'b1;
        e.opa  = a;
        e.opb  = b;
        e.sel  = s;
        return e;
    endfunction

    task automatic cmp(input exp_t e);
        bit ok;
        checks++;
        ok = e.full ? (display === e.disp && disp_neg === e.neg && error === e.err && key_ready === e.rdy &&
                       op_a === e.opa && op_b === e.opb && op_sel === e.sel)
                    : (key_ready === e.rdy);
        if (!ok) begin
            fails++;
            $display("FAIL %s: got disp=%h neg=%b err=%b rdy=%b a=%h b=%h sel=%0d, want disp=%h neg=%b err=%b rdy=%b a=%h b=%h sel=%0d%s",
                     e.name, display, disp_neg, error, key_ready, op_a, op_b, op_sel,
                     e.disp, e.neg, e.err, e.rdy, e.opa, e.opb, e.sel, e.full ? "" : " (key_ready only)");
        end
    endtask

    // Monitor: results are checked when key_ready returns high; probes at the next mid-cycle.
    always @(negedge clk) begin
        if (rdy_q === 1'b0 && key_ready === 1'b1) begin
            if (res_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_result: display=%h with no result expected", display);
            end else begin
                cmp(res_q.pop_front());
            end
        end
        while (probe_q.size() > 0)
            cmp(probe_q.pop_front());
        rdy_q = key_ready;
    end

    function automatic logic [3:0] code_of(input byte ch);
        case (ch)
            8'h2B:   return 4'hA;
            8'h2D:   return 4'hB;
            8'h2A:   return 4'hC;
            8'h25:   return 4'hD;
            8'h3D:   return 4'hE;
            8'h43:   return 4'hF;
            default: return 4'(ch - 8'h30);
        endcase
    endfunction

    task automatic key(input logic [3:0] c);
        @(posedge clk);
        #1 key_valid = 1'b1;
        key_code = c;
        @(posedge clk);
        #1 key_valid = 1'b0;
    endtask

    task automatic press(input string s);
        for (int i = 0; i < s.len(); i++)
            key(code_of(s[i]));
    endtask

    task automatic expect_now(input exp_t e);
        probe_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_res(input string n);
        for (int i = 0; i < 10 && res_q.size() > 0; i++)
            @(posedge clk);
        if (res_q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout: result not presented, pending=%0d required=0", n, res_q.size());
            res_q.delete();
        end
    endtask

    initial begin
        exp_t p;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        expect_now(ex("reset", 16'h0, 0, 0, 16'h0, 16'h0, 2'd0));

        press("12345");
        expect_now(ex("fifth_digit_dropped", 16'h1234, 0, 0, 16'h1234, 16'h0, 2'd0));
        press("C");
        expect_now(ex("clear_in_a", 16'h0, 0, 0, 16'h0, 16'h0, 2'd0));
        press("007");
        expect_now(ex("leading_zeros", 16'h0007, 0, 0, 16'h0007, 16'h0, 2'd0));
        press("=");
        expect_now(ex("eq_in_a_ignored", 16'h0007, 0, 0, 16'h0007, 16'h0, 2'd0));
        press("+3");
        expect_now(ex("enter_b", 16'h0003, 0, 0, 16'h0007, 16'h0003, 2'd0));
        res_q.push_back(ex("add_result", 16'h0010, 0, 0, 16'h0007, 16'h0003, 2'd0));
        press("=");
        wait_res("add_result");

        press("C12-34");
        res_q.push_back(ex("sub_negative", 16'h0022, 1, 0, 16'h0012, 16'h0034, 2'd1));
        press("=");
        wait_res("sub_negative");
        press("+");
        expect_now(ex("op_after_neg_ignored", 16'h0022, 1, 0, 16'h0012, 16'h0034, 2'd1));

        press("C9999+1");
        res_q.push_back(ex("add_overflow", 16'hFFFF, 0, 1, 16'h9999, 16'h0001, 2'd0));
        press("=");
        wait_res("add_overflow");
        press("5");
        expect_now(ex("digit_in_err_ignored", 16'hFFFF, 0, 1, 16'h9999, 16'h0001, 2'd0));
        press("C");
        expect_now(ex("clear_from_err", 16'h0, 0, 0, 16'h0, 16'h0, 2'd0));

        press("5%0");
        res_q.push_back(ex("mod_div0", 16'hFFFF, 0, 1, 16'h0005, 16'h0, 2'd3));
        press("=");
        wait_res("mod_div0");
        press("C2*3");
        res_q.push_back(ex("mul_result", 16'h0006, 0, 0, 16'h0002, 16'h0003, 2'd2));
        press("=");
        wait_res("mul_result");
        press("*");
        expect_now(ex("chain_op", 16'h0006, 0, 0, 16'h0006, 16'h0, 2'd2));
        press("4");
        expect_now(ex("chain_b", 16'h0004, 0, 0, 16'h0006, 16'h0004, 2'd2));
        res_q.push_back(ex("chain_result", 16'h0024, 0, 0, 16'h0006, 16'h0004, 2'd2));
        press("=");
        wait_res("chain_result");
        press("8");
        expect_now(ex("digit_after_result", 16'h0008, 0, 0, 16'h0008, 16'h0, 2'd2));

        press("C0001234");
        expect_now(ex("zeros_then_digits", 16'h1234, 0, 0, 16'h1234, 16'h0, 2'd0));
        press("C5+-2");
        res_q.push_back(ex("op_replaced", 16'h0003, 0, 0, 16'h0005, 16'h0002, 2'd1));
        press("=");
        wait_res("op_replaced");

        press("C6*7");
        res_q.push_back(ex("exec_result", 16'h0042, 0, 0, 16'h0006, 16'h0007, 2'd2));
        @(posedge clk);
        #1 key_valid = 1'b1;
        key_code = 4'hE;
        @(posedge clk);
        #1 key_code = 4'h9;
        p = ex("exec_not_ready", 16'h0, 0, 0, 16'h0, 16'h0, 2'd0);
        p.full = 1'b0;
        p.rdy = 1'b0;
        probe_q.push_back(p);
        @(posedge clk);
        #1 key_valid = 1'b0;
        wait_res("exec_result");
        expect_now(ex("exec_key_dropped", 16'h0042, 0, 0, 16'h0006, 16'h0007, 2'd2));

        press("C12");
        @(posedge clk);
        #1 rst = 1'b1;
        key_valid = 1'b1;
        key_code = 4'h7;
        @(posedge clk);
        #1 rst = 1'b0;
        key_valid = 1'b0;
        expect_now(ex("rst_over_key", 16'h0, 0, 0, 16'h0, 16'h0, 2'd0));

        repeat (5) @(posedge clk);
        if (probe_q.size() + res_q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL unconsumed_expectations: pending=%0d required=0", probe_q.size() + res_q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule
